buffer_stream_feeder: RTL and testbench
=======================================

BUFFER_STREAM_FEEDER -- requirements
Module: buffer_stream_feeder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning skid-FIFO depth in 64-bit pairs (power of two, >=2).
REQ-002 SHALL have ports, clock and reset first:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a transfer of len pairs
- len  input  14  number of 64-bit pairs to stream; sampled on accepted start
- buf_state  output  2  command to upstream buffer: 2'b00 idle, 2'b10 stream one pair; 2'b01 never driven
- buf_data  input  64  upstream buffer output; {hi word, lo word}; valid exactly one cycle after a cycle with buf_state==2'b10
- a_row0  output  32  systolic row-0 operand
- a_row1  output  32  systolic row-1 operand, skewed one beat behind row 0
- out_valid  output  1  a_row0/a_row1/out_last valid
- out_ready  input  1  array accepts beat when out_valid&&out_ready
- out_last  output  1  marks final beat of a transfer
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse at end of transfer

Function
REQ-003 SHALL implement FSM IDLE -> STREAM -> DONE -> IDLE.
REQ-004 IDLE: start=1 SHALL latch len, clear counters, enter STREAM, raise busy next cycle; start in STREAM/DONE SHALL be ignored.
REQ-005 start with len==0 SHALL go directly to DONE: no buf_state==2'b10 issued, no output beats, done pulse.
REQ-006 In STREAM, buf_state SHALL be 2'b10 for a cycle only if issued<len and fifo_count+inflight<FIFO_DEPTH; otherwise 2'b00.
REQ-007 Each issue SHALL set an inflight flag; next cycle buf_data SHALL be written into the skid FIFO unconditionally (credit rule guarantees space); FIFO SHALL never overflow.
REQ-008 Output beats SHALL be numbered k=0..len (len+1 beats); beat k: a_row0=hi(pair k) for k<len, 0 for k==len; a_row1=lo(pair k-1) for k>0, 0 for k==0.
REQ-009 out_valid SHALL assert for beat k<len only when FIFO non-empty; beat len (flush) SHALL need no FIFO data.
REQ-010 On handshake of beat k<len, FIFO SHALL pop and a skew register SHALL capture lo(pair k).
REQ-011 While out_valid&&!out_ready, a_row0, a_row1, out_last SHALL hold stable; out_valid SHALL not drop.
REQ-012 out_last SHALL be 1 only with beat k==len.
REQ-013 FIFO push and pop in same cycle SHALL leave fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-014 Handshake of beat len SHALL move FSM to DONE; DONE SHALL last one cycle with done=1, busy=0, then IDLE.
REQ-015 issued and beat counters SHALL be 15 bits internally so len=16383 completes without wrap.
REQ-016 out_valid SHALL be 0 in IDLE and DONE; a_row0/a_row1 SHALL be 0 whenever out_valid=0.

Reset
REQ-017 rst=1 SHALL asynchronously force: FSM IDLE, buf_state=2'b00, out_valid=0, out_last=0, a_row0=0, a_row1=0, busy=0, done=0, FIFO empty, inflight=0, counters 0.
REQ-018 rst mid-transfer SHALL abort with no further issues or beats; pending buf_data SHALL be discarded; next start SHALL behave as from cold reset.

Verification
REQ-019 len=3, pairs {A1,A0},{B1,B0},{C1,C0}, out_ready=1 -> beats (row0,row1): (A1,0),(B1,A0),(C1,B0),(0,C0) with out_last on 4th, done one cycle after.
REQ-020 len=8, out_ready=0 for 20 cycles then 1 -> exactly FIFO_DEPTH issues before stall, no overflow, first beat held stable, all 9 beats correct in order.
REQ-021 len=0 start -> no buf_state==2'b10, out_valid never 1, done pulses once, busy low.
REQ-022 out_ready toggling 1/0 each cycle, len=5 -> 6 beats, data correct, simultaneous push/pop keeps count consistent.
REQ-023 rst asserted mid-transfer of len=10 after 4 beats -> all outputs 0 same cycle; new start len=2 yields (X1,0),(Y1,X0),(0,Y0).
REQ-024 start pulsed again while busy -> ignored; original transfer completes unchanged.

Source files
------------

// File: rtl/buffer_stream_feeder.sv
// buffer_stream_feeder: streams 64-bit buffer pairs through a skid FIFO into a two-row skewed systolic feed
module buffer_stream_feeder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] len,
    output logic [1:0]  buf_state,
    input  logic [63:0] buf_data,
    output logic [31:0] a_row0,
    output logic [31:0] a_row1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [13:0]   r_len;
    logic [14:0]   r_issued;
    logic [14:0]   r_beat;
    logic          r_inflight;
    logic [63:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic [31:0]   r_skew;
    logic          w_accept;
    logic          w_issue;
    logic          w_flush;
    logic          w_hs;
    logic          w_pop;
    logic          w_credit;

    // Next-state, buffer command and output-beat decode
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_issue   = 1'b0;
        out_valid = 1'b0;
        w_flush   = r_beat == {1'b0, r_len};
        w_credit  = (AW+2)'(r_cnt) + (AW+2)'(r_inflight) < (AW+2)'(FIFO_DEPTH);
        case (r_state)
            S_IDLE: begin
                w_accept = start;
                w_next   = !start ? S_IDLE : (len == '0 ? S_DONE : S_STREAM);
            end
            S_STREAM: begin
                w_issue   = r_issued < {1'b0, r_len} && w_credit;
                out_valid = w_flush || r_cnt != '0;
                w_next    = out_valid && out_ready && w_flush ? S_DONE : S_STREAM;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        w_hs      = out_valid && out_ready;
        w_pop     = w_hs && !w_flush;
        buf_state = w_issue ? 2'b10 : 2'b00;
        out_last  = out_valid && w_flush;
        a_row0    = out_valid && !w_flush ? r_mem[r_rp][63:32] : '0;
        a_row1    = out_valid && r_beat != '0 ? r_skew : '0;
        busy      = r_state == S_STREAM;
        done      = r_state == S_DONE;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Transfer counters, credit flag, FIFO pointers/occupancy and row-1 skew register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len      <= '0;
            r_issued   <= '0;
            r_beat     <= '0;
            r_inflight <= 1'b0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_cnt      <= '0;
            r_skew     <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_accept) begin
                r_len    <= len;
                r_issued <= '0;
                r_beat   <= '0;
                r_skew   <= '0;
            end else begin
                if (w_issue) r_issued <= r_issued + 15'd1;
                if (w_pop) begin
                    r_beat <= r_beat + 15'd1;
                    r_skew <= r_mem[r_rp][31:0];
                    r_rp   <= r_rp + AW'(1);
                end
                if (r_inflight) r_wp <= r_wp + AW'(1);
                r_cnt <= r_cnt + (AW+1)'(r_inflight) - (AW+1)'(w_pop);
            end
        end
    end

    // Skid FIFO storage; the pair requested last cycle lands here unconditionally
    always_ff @(posedge clk) begin
        if (r_inflight) r_mem[r_wp] <= buf_data;
    end
endmodule

// File: tb/tb_buffer_stream_feeder.sv
// tb_buffer_stream_feeder: directed vector bench for buffer_stream_feeder
module tb_buffer_stream_feeder;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [13:0] len = '0;
    logic [1:0]  buf_state;
    logic [63:0] buf_data;
    logic [31:0] a_row0, a_row1;
    logic        out_valid, out_last, busy, done;
    logic        out_ready = 1'b0;

    int n_vec = 0, n_bad = 0;
    int n_iss = 0, n_pop = 0, n_done = 0, n_busy = 0, n_proto = 0, n_ovf = 0;
    logic [31:0] q0[$], q1[$];
    logic        ql[$];
    logic        prev_stall = 1'b0, pl;
    logic [31:0] p0, p1;

    typedef struct {
        int len;
        int rmode;
        int beats;
        int iss;
        int busy_seen;
    } vec_t;

    always #5 clk = ~clk;

    buffer_stream_feeder #(.FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .buf_state(buf_state),
        .buf_data(buf_data), .a_row0(a_row0), .a_row1(a_row1), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
    );

    function automatic logic [63:0] pair(input int i);
        return {16'hA1A1, i[15:0], 16'hB0B0, i[15:0]};
    endfunction

    // Upstream buffer model: registered read, pair index restarts on every accepted start
    always @(posedge clk or posedge rst) begin
        if (rst) n_iss <= 0;
        else if (start && !busy && !done) n_iss <= 0;
        else if (buf_state == 2'b10) begin
            buf_data <= pair(n_iss);
            n_iss    <= n_iss + 1;
        end
    end

    // Beat collector and protocol monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (start && !busy && !done) begin
            q0.delete(); q1.delete(); ql.delete();
            n_pop = 0; n_done = 0; n_busy = 0; prev_stall = 1'b0;
        end else if (rst) prev_stall = 1'b0;
        else begin
            if (prev_stall && !(out_valid && a_row0 == p0 && a_row1 == p1 && out_last == pl)) n_proto++;
            if (!out_valid && (a_row0 != 0 || a_row1 != 0 || out_last)) n_proto++;
            if (buf_state == 2'b01) n_proto++;
            if (done && busy) n_proto++;
            if (n_iss - n_pop > D) n_ovf++;
            if (done) n_done++;
            if (busy) n_busy++;
            if (out_valid && out_ready) begin
                q0.push_back(a_row0); q1.push_back(a_row1); ql.push_back(out_last);
                if (!out_last) n_pop++;
            end
            prev_stall = out_valid && !out_ready;
            p0 = a_row0; p1 = a_row1; pl = out_last;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // rmode: 0 ready high, 1 ready toggles, 2 ready low 20 cycles, 3 ready high plus a stray start
    task automatic run(input vec_t v);
        int cyc = 0;
        logic [63:0] p;
        len = 14'(v.len); start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (n_done == 0 && cyc < 4 * v.len + 100) begin
            out_ready = v.rmode == 1 ? (cyc % 2 == 0) : v.rmode == 2 ? (cyc >= 20) : 1'b1;
            start = v.rmode == 3 && cyc == 2;
            if (start) len = 14'd2;
            if (v.rmode == 2 && cyc == 19 && v.len >= D) begin
                p = pair(0);
                chk("stall_issues", 64'(n_iss), 64'(D));
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_row0", 64'(a_row0), 64'(p[63:32]));
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("done_seen", 64'(n_done > 0), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", 64'(n_done), 64'd1);
        chk("beat_count", 64'(q0.size()), 64'(v.beats));
        chk("issue_count", 64'(n_iss), 64'(v.iss));
        chk("busy_seen", 64'(n_busy > 0), 64'(v.busy_seen));
        chk("busy_after", 64'(busy), 64'd0);
        chk("overflow", 64'(n_ovf), 64'd0);
        chk("protocol", 64'(n_proto), 64'd0);
        for (int k = 0; k < q0.size(); k++) begin
            p = pair(k);
            chk("beat_row0", 64'(q0[k]), k < v.len ? 64'(p[63:32]) : 64'd0);
            p = pair(k - 1);
            chk("beat_row1", 64'(q1[k]), k > 0 ? 64'(p[31:0]) : 64'd0);
            chk("beat_last", 64'(ql[k]), 64'(k == v.len));
        end
    endtask

    initial begin
        vec_t vecs[8];
        int cyc;
        vecs[0] = '{3, 0, 4, 3, 1};
        vecs[1] = '{8, 2, 9, 8, 1};
        vecs[2] = '{0, 0, 0, 0, 0};
        vecs[3] = '{5, 1, 6, 5, 1};
        vecs[4] = '{5, 3, 6, 5, 1};
        vecs[5] = '{1, 1, 2, 1, 1};
        vecs[6] = '{4, 2, 5, 4, 1};
        vecs[7] = '{16383, 0, 16384, 16383, 1};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rows", {a_row0, a_row1}, 64'd0);
        chk("reset_ctl", 64'({out_valid, out_last, busy, done, buf_state}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run(vecs[0]);
        if (q0.size() == 4) begin
            chk("ex3_b0", {q0[0], q1[0]}, {32'hA1A10000, 32'h0});
            chk("ex3_b1", {q0[1], q1[1]}, {32'hA1A10001, 32'hB0B00000});
            chk("ex3_b2", {q0[2], q1[2]}, {32'hA1A10002, 32'hB0B00001});
            chk("ex3_b3", {q0[3], q1[3]}, {32'h0, 32'hB0B00002});
            chk("ex3_last", 64'({ql[0], ql[1], ql[2], ql[3]}), 64'b0001);
        end

        for (int i = 1; i < 8; i++) run(vecs[i]);

        len = 14'd10; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (q0.size() < 4 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("abort_reached", 64'(q0.size() >= 4), 64'd1);
        chk("abort_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_rows", {a_row0, a_row1}, 64'd0);
        chk("abort_ctl", 64'({out_valid, out_last, busy, done, buf_state}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_issue", 64'(n_iss), 64'd0);
        chk("abort_quiet", 64'({out_valid, busy, done}), 64'd0);

        run('{2, 0, 3, 2, 1});
        if (q0.size() == 3) begin
            chk("post_b0", {q0[0], q1[0]}, {32'hA1A10000, 32'h0});
            chk("post_b1", {q0[1], q1[1]}, {32'hA1A10001, 32'hB0B00000});
            chk("post_b2", {q0[2], q1[2]}, {32'h0, 32'hB0B00001});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
